// File: rtl/part_test_ctrl.sv
//------------------------------------------------------------------------------
// part_test_ctrl
//   Sequences a partition-test run: enables the test for N cycles, snapshots
//   the eight bin counters and the total, then drains them over a
//   valid/ready port. Optional macro PART_TEST_CTRL_CHECK_EN adds a total check.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module part_test_ctrl (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_n_samples,
  output logic             o_test_en,
  input  logic [7:0][63:0] i_bin_in,
  input  logic [63:0]      i_total_in,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [63:0]      o_rd_data,
  output logic             o_rd_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam logic [3:0] c_LAST_IDX = 4'd8;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_idx;
  logic        r_test_en;
  logic        r_rd_valid;
  logic        r_rd_last;
  logic [63:0] r_rd_data;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_snap [0:8];

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [3:0]  w_idx_nxt;
  logic        w_test_en_nxt;
  logic        w_rd_valid_nxt;
  logic        w_rd_last_nxt;
  logic [63:0] w_rd_data_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_start_acc;
  logic        w_snap_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 32'd0;
      r_idx      <= 4'd0;
      r_test_en  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= 64'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_test_en  <= w_test_en_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_last  <= w_rd_last_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_test_en_nxt  = r_test_en;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_last_nxt  = r_rd_last;
    w_rd_data_nxt  = r_rd_data;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_start_acc    = 1'b0;
    w_snap_en      = 1'b0;

    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = 32'd0;
      w_idx_nxt      = 4'd0;
      w_test_en_nxt  = 1'b0;
      w_rd_valid_nxt = 1'b0;
      w_rd_last_nxt  = 1'b0;
      w_rd_data_nxt  = 64'd0;
      w_busy_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort && (i_n_samples != 32'd0)) begin
            w_start_acc   = 1'b1;
            w_state_nxt   = S_RUN;
            w_cnt_nxt     = i_n_samples;
            w_test_en_nxt = 1'b1;
            w_busy_nxt    = 1'b1;
          end
        end
        S_RUN: begin
          // Counter holds remaining enabled cycles including the current one.
          if (r_cnt == 32'd1) begin
            w_state_nxt   = S_CAPTURE;
            w_cnt_nxt     = 32'd0;
            w_test_en_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 32'd1;
          end
        end
        S_CAPTURE: begin
          // Snapshot loads on this edge, so the first word comes straight from the input.
          w_snap_en      = 1'b1;
          w_state_nxt    = S_DRAIN;
          w_idx_nxt      = 4'd0;
          w_rd_valid_nxt = 1'b1;
          w_rd_last_nxt  = 1'b0;
          w_rd_data_nxt  = i_bin_in[0];
        end
        S_DRAIN: begin
          if (r_rd_valid && i_rd_ready) begin
            if (r_idx == c_LAST_IDX) begin
              w_state_nxt    = S_IDLE;
              w_idx_nxt      = 4'd0;
              w_rd_valid_nxt = 1'b0;
              w_rd_last_nxt  = 1'b0;
              w_busy_nxt     = 1'b0;
              w_done_nxt     = 1'b1;
            end else begin
              w_idx_nxt     = r_idx + 4'd1;
              w_rd_data_nxt = r_snap[r_idx + 4'd1];
              w_rd_last_nxt = ((r_idx + 4'd1) == c_LAST_IDX);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        r_snap[k] <= 64'd0;
      end
    end else if (w_snap_en) begin
      for (int k = 0; k < 8; k++) begin
        r_snap[k] <= i_bin_in[k];
      end
      r_snap[8] <= i_total_in;
    end
  end

`ifdef PART_TEST_CTRL_CHECK_EN
  logic [31:0] r_n;
  logic        r_err;
  logic [65:0] w_expect_total;
  logic        w_mismatch;

  // Four words are counted per enabled cycle.
  assign w_expect_total = {32'd0, r_n, 2'b00};
  assign w_mismatch     = ({2'b00, i_total_in} != w_expect_total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n   <= 32'd0;
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_n   <= i_n_samples;
      r_err <= 1'b0;
    end else if (w_snap_en && w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_test_en  = r_test_en;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_last  = r_rd_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_part_test_ctrl.sv
//------------------------------------------------------------------------------
// tb_part_test_ctrl
//   Directed table-driven bench for part_test_ctrl with a partition-test model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_part_test_ctrl;

  logic             clk;
  logic             rst;
  logic             i_start;
  logic             i_abort;
  logic [31:0]      i_n_samples;
  logic             o_test_en;
  logic [7:0][63:0] i_bin_in;
  logic [63:0]      i_total_in;
  logic             o_rd_valid;
  logic             i_rd_ready;
  logic [63:0]      o_rd_data;
  logic             o_rd_last;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  part_test_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_n_samples (i_n_samples),
    .o_test_en   (o_test_en),
    .i_bin_in    (i_bin_in),
    .i_total_in  (i_total_in),
    .o_rd_valid  (o_rd_valid),
    .i_rd_ready  (i_rd_ready),
    .o_rd_data   (o_rd_data),
    .o_rd_last   (o_rd_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partition-test model: each enabled cycle bumps the masked bins and adds 4 to total.
  logic [63:0] m_bin [8];
  logic [63:0] m_total;
  logic [7:0]  m_mask;
  logic        m_force_tot;

  always @(posedge clk) begin
    if (!o_test_en) begin
      for (int k = 0; k < 8; k++) m_bin[k] <= 64'd0;
      m_total <= 64'd0;
    end else begin
      for (int k = 0; k < 8; k++) if (m_mask[k]) m_bin[k] <= m_bin[k] + 64'd1;
      m_total <= m_total + 64'd4;
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) i_bin_in[k] = m_bin[k];
    i_total_in = m_force_tot ? 64'd15 : m_total;
  end

  typedef struct {
    logic [31:0]      n;
    logic [7:0]       mask;
    int               stall_word;
    int               stall_len;
    bit               start_mid;
    bit               force_tot;
    bit               exp_err;
    logic [8:0][63:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] n, input logic [7:0] mask,
                               input int sw, input int sl, input bit sm,
                               input bit ft, input bit ee, input logic [63:0] tot);
    vec_t v;
    v.n = n; v.mask = mask; v.stall_word = sw; v.stall_len = sl;
    v.start_mid = sm; v.force_tot = ft; v.exp_err = ee;
    for (int k = 0; k < 8; k++) v.exp[k] = mask[k] ? {32'd0, n} : 64'd0;
    v.exp[8] = tot;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [63:0] words [9];
    logic        lasts [9];
    logic [63:0] held;
    int en_cnt, idx, stall, bubbles, guard, last_cnt, extra_done;
    bit got_done, in_drain;
    en_cnt = 0; idx = 0; stall = 0; bubbles = 0; guard = 0; last_cnt = 0;
    got_done = 0; in_drain = 0; held = '0;
    m_mask = v.mask; m_force_tot = v.force_tot;
    @(negedge clk);
    i_n_samples = v.n; i_start = 1'b1; i_rd_ready = 1'b1;
    while (!got_done && guard < 300) begin
      @(negedge clk);
      guard++;
      i_start = 1'b0;
      if (o_test_en) en_cnt++;
      if (o_done) begin
        got_done = 1;
      end else if (o_rd_valid) begin
        in_drain = 1;
        if (idx == v.stall_word && stall < v.stall_len) begin
          i_rd_ready = 1'b0;
          if (stall > 0) chk($sformatf("v%0d_stall_hold", id), o_rd_data, held);
          held = o_rd_data;
          stall++;
        end else begin
          i_rd_ready = 1'b1;
          if (idx < 9) begin
            words[idx] = o_rd_data;
            lasts[idx] = o_rd_last;
            if (v.start_mid && idx == 4) begin
              i_start = 1'b1;
              i_n_samples = 32'd7;
            end
          end
          idx++;
        end
      end else if (in_drain) begin
        bubbles++;
      end
    end
    chk($sformatf("v%0d_done_seen", id), {63'd0, got_done}, 64'd1);
    chk($sformatf("v%0d_busy_at_done", id), {63'd0, o_busy}, 64'd0);
    chk($sformatf("v%0d_valid_at_done", id), {63'd0, o_rd_valid}, 64'd0);
    chk($sformatf("v%0d_err", id), {63'd0, o_err}, {63'd0, v.exp_err});
    chk($sformatf("v%0d_test_en_cycles", id), en_cnt, {32'd0, v.n});
    chk($sformatf("v%0d_handshakes", id), idx, 64'd9);
    chk($sformatf("v%0d_bubbles", id), bubbles, 64'd0);
    for (int k = 0; k < 9; k++) begin
      if (k < idx) begin
        chk($sformatf("v%0d_word%0d", id, k), words[k], v.exp[k]);
        if (lasts[k]) last_cnt++;
      end
    end
    chk($sformatf("v%0d_last_count", id), last_cnt, 64'd1);
    if (idx >= 9) chk($sformatf("v%0d_last_on_9th", id), {63'd0, lasts[8]}, 64'd1);
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) extra_done++;
      if (o_busy) extra_done++;
    end
    chk($sformatf("v%0d_quiet_after_done", id), extra_done, 64'd0);
    m_force_tot = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    int cnt, bad, guard;
`ifdef PART_TEST_CTRL_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_n_samples = 32'd0;
    i_rd_ready = 1'b1; m_mask = 8'h00; m_force_tot = 1'b0;

    vecs[0] = mkv(32'd1, 8'h01, -1, 0, 0, 0, 0, 64'd4);
    vecs[1] = mkv(32'd5, 8'hFF, -1, 0, 0, 0, 0, 64'd20);
    vecs[2] = mkv(32'd3, 8'hA5,  2, 4, 0, 0, 0, 64'd12);
    vecs[3] = mkv(32'd6, 8'h3C, -1, 0, 1, 0, 0, 64'd24);
    vecs[4] = mkv(32'd4, 8'h0F, -1, 0, 0, 1, chk_en, 64'd15);
    vecs[5] = mkv(32'd2, 8'h81, -1, 0, 0, 0, 0, 64'd8);

    repeat (2) @(negedge clk);
    chk("rst_test_en", {63'd0, o_test_en}, 64'd0);
    chk("rst_valid", {63'd0, o_rd_valid}, 64'd0);
    chk("rst_last", {63'd0, o_rd_last}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    chk("rst_data", o_rd_data, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // start with zero length is ignored
    @(negedge clk);
    i_n_samples = 32'd0; i_start = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy || o_test_en || o_done) bad++;
    end
    chk("zero_n_ignored", bad, 64'd0);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    i_n_samples = 32'd5; i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    chk("abort_start_idle_busy", {63'd0, o_busy}, 64'd0);

    // abort on the third RUN cycle
    m_mask = 8'hFF;
    @(negedge clk);
    i_n_samples = 32'd10; i_start = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 3 && guard < 20) begin
      @(negedge clk);
      guard++;
      i_start = 1'b0;
      if (o_test_en) cnt++;
    end
    chk("abort_reach_run3", cnt, 64'd3);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_test_en", {63'd0, o_test_en}, 64'd0);
    chk("abort_busy", {63'd0, o_busy}, 64'd0);
    chk("abort_valid", {63'd0, o_rd_valid}, 64'd0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (o_rd_valid || o_done || o_test_en || o_busy) bad++;
    end
    chk("abort_quiet", bad, 64'd0);
    run_vec(mkv(32'd2, 8'hFF, -1, 0, 0, 0, 0, 64'd8), 6);

    // reset mid-drain acts like abort, no done on release
    m_mask = 8'h01;
    @(negedge clk);
    i_n_samples = 32'd2; i_start = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      i_start = 1'b0;
      guard++;
    end while (!o_rd_valid && guard < 20);
    chk("rstmid_reach_drain", {63'd0, o_rd_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", {63'd0, o_rd_valid}, 64'd0);
    chk("rstmid_busy", {63'd0, o_busy}, 64'd0);
    chk("rstmid_data", o_rd_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_done || o_busy || o_rd_valid) bad++;
    end
    chk("rstmid_quiet", bad, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
